// File: rtl/hb_pkg.sv
// Shared half-band constants for the 2x interpolator and decimator.
package hb_pkg;
  localparam int NUM_TAPS   = 14;
  localparam int NUM_PAIRS  = NUM_TAPS / 2;
  localparam int SAMPLE_W   = 16;
  localparam int CENTER_Q15 = 16384;

  // Q15 outer-tap coefficients, symmetric about the center tap.
  localparam logic signed [15:0] W [0:NUM_PAIRS-1] = '{
    16'sd1, -16'sd10, 16'sd64, -16'sd275, 16'sd897, -16'sd2577, 16'sd10091
  };
endpackage

// File: rtl/hb_sat16.sv
// Arithmetic right shift (floor) followed by clamp to signed 16-bit.
module hb_sat16 #(
  parameter int SHIFT = 14
) (
  input  logic signed [35:0] acc_i,
  output logic signed [15:0] y_o
);
  logic signed [35:0] sh;

  // Shift then clamp to [-32768, 32767].
  always_comb begin
    sh = acc_i >>> SHIFT;
    if (sh > 36'sd32767)       y_o = 16'sh7fff;
    else if (sh < -36'sd32768) y_o = 16'sh8000;
    else                       y_o = sh[15:0];
  end
endmodule

// File: rtl/hb_interp2.sv
// 2x half-band interpolator: one input per 6 clocks, two outputs per input.
// Phase A is the polyphase FIR over the outer taps, phase B is the center
// tap passed straight through (0.5 coefficient times gain 2 is exact).
module hb_interp2
  import hb_pkg::*;
#(
  parameter int COEF_SHIFT = 14
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] x_in,
  input  logic        x_in_valid,
  output logic        x_in_ready,
  output logic [15:0] y_out,
  output logic        y_out_valid
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PAIR  = 3'd1,
    MULT  = 3'd2,
    SUM   = 3'd3,
    OUT_A = 3'd4,
    OUT_B = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic signed [SAMPLE_W-1:0] t_q [NUM_TAPS];
  logic signed [SAMPLE_W:0]   p_q [NUM_PAIRS];
  logic signed [32:0]         m_q [NUM_PAIRS];
  logic signed [35:0]         acc_q, acc_d;
  logic signed [15:0]         sat_y;
  logic                       accept;

  assign x_in_ready = (state_q == IDLE);
  assign accept     = x_in_valid && x_in_ready;

  // Next-state: IDLE waits for a sample, every other state lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = PAIR;
      PAIR:    state_d = MULT;
      MULT:    state_d = SUM;
      SUM:     state_d = OUT_A;
      OUT_A:   state_d = OUT_B;
      OUT_B:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Adder tree over the registered products.
  always_comb begin
    acc_d = '0;
    for (int j = 0; j < NUM_PAIRS; j++) acc_d = acc_d + 36'(m_q[j]);
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Delay line shifts only on acceptance, so it stays frozen during a pass.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_TAPS; k++) t_q[k] <= '0;
    end else if (accept) begin
      t_q[0] <= x_in;
      for (int k = 1; k < NUM_TAPS; k++) t_q[k] <= t_q[k-1];
    end
  end

  // Datapath pipeline: symmetric pair sums, products, accumulate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < NUM_PAIRS; j++) begin
        p_q[j] <= '0;
        m_q[j] <= '0;
      end
      acc_q <= '0;
    end else begin
      if (state_q == PAIR)
        for (int j = 0; j < NUM_PAIRS; j++)
          p_q[j] <= (SAMPLE_W+1)'(t_q[j]) + (SAMPLE_W+1)'(t_q[NUM_TAPS-1-j]);
      if (state_q == MULT)
        for (int j = 0; j < NUM_PAIRS; j++)
          m_q[j] <= 33'(p_q[j]) * 33'(W[j]);
      if (state_q == SUM)
        acc_q <= acc_d;
    end
  end

  hb_sat16 #(.SHIFT(COEF_SHIFT)) u_sat (
    .acc_i (acc_q),
    .y_o   (sat_y)
  );

  // Output register: phase A then phase B, holding value between strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_out       <= '0;
      y_out_valid <= 1'b0;
    end else begin
      y_out_valid <= (state_q == OUT_A) || (state_q == OUT_B);
      if (state_q == OUT_A)      y_out <= sat_y;
      else if (state_q == OUT_B) y_out <= t_q[NUM_PAIRS-1];
    end
  end
endmodule

// File: tb/tb_hb_interp2.sv
// Scoreboard bench for hb_interp2: driver pushes expected outputs on
// acceptance, a negedge monitor pops and compares on every y_out_valid.
module tb_hb_interp2;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] x_in = '0;
  logic        x_in_valid = 1'b0;
  logic        x_in_ready;
  logic [15:0] y_out;
  logic        y_out_valid;

  typedef struct {
    logic        chk;
    logic [15:0] v;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_valid = 0;

  hb_interp2 #(.COEF_SHIFT(14)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .x_in        (x_in),
    .x_in_valid  (x_in_valid),
    .x_in_ready  (x_in_ready),
    .y_out       (y_out),
    .y_out_valid (y_out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%04h) expected %0d (0x%04h)",
               nm, $signed(act), act, $signed(req), req);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (reset_n && y_out_valid) begin
      n_valid++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: got y_out=%0d with empty scoreboard", $signed(y_out));
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk) check(e.nm, y_out, e.v);
      end
    end
  end

  task automatic push(input logic ca, input logic [15:0] a, input logic cb,
                      input logic [15:0] b, input string nm);
    exp_t e;
    e.chk = ca; e.v = a; e.nm = {nm, "_A"}; sb.push_back(e);
    e.chk = cb; e.v = b; e.nm = {nm, "_B"}; sb.push_back(e);
  endtask

  task automatic send(input logic [15:0] x, input logic ca, input logic [15:0] a,
                      input logic cb, input logic [15:0] b, input string nm);
    int n;
    @(negedge clk);
    x_in = x;
    x_in_valid = 1'b1;
    n = 0;
    while (!x_in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!x_in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL %s_ready_timeout: x_in_ready=0 required 1", nm);
    end else begin
      @(posedge clk);
      push(ca, a, cb, b, nm);
    end
  endtask

  task automatic drain();
    int n;
    @(negedge clk);
    x_in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d outputs pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic [15:0] imp_a [20];
  logic [15:0] dc_a  [14];
  logic [15:0] pv, nv, tmp;
  logic [13:0] sat_sgn;

  initial begin
    int vprev;
    logic rdy_prev;

    imp_a = '{16'd1, -16'sd10, 16'd64, -16'sd275, 16'd897, -16'sd2577, 16'd10091,
              16'd10091, -16'sd2577, 16'd897, -16'sd275, 16'd64, -16'sd10, 16'd1,
              16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    dc_a  = '{16'd0, -16'sd1, 16'd3, -16'sd14, 16'd41, -16'sd116, 16'd499,
              16'd1115, 16'd958, 16'd1013, 16'd996, 16'd1000, 16'd999, 16'd999};

    // Reset state
    #12;
    check("rst_ready", {15'd0, x_in_ready}, 16'd1);
    check("rst_y_out", y_out, 16'd0);
    check("rst_valid", {15'd0, y_out_valid}, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Impulse
    for (int k = 0; k < 20; k++)
      send((k == 0) ? 16'd16384 : 16'd0, 1'b1, imp_a[k], 1'b1,
           (k == 6) ? 16'd16384 : 16'd0, $sformatf("imp%0d", k));
    drain();

    // DC
    do_reset();
    for (int k = 0; k < 20; k++)
      send(16'd1000, 1'b1, (k < 14) ? dc_a[k] : 16'd999, 1'b1,
           (k >= 6) ? 16'd1000 : 16'd0, $sformatf("dc%0d", k));
    drain();

    // Saturation, then sign-inverted
    sat_sgn = 14'b10101011010101; // bit 13 = first input, '1' = positive
    pv = 16'h7fff; nv = 16'h8000;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 14; k++) begin
        tmp = sat_sgn[13-k] ? pv : nv;
        send(tmp, k == 13, pv, k == 13, pv, $sformatf("sat%0d_%0d", pass, k));
      end
      tmp = pv; pv = nv; nv = tmp;
    end
    drain();

    // Continuous valid: handshake cadence
    do_reset();
    @(negedge clk);
    x_in = 16'd0;
    x_in_valid = 1'b1;
    for (int n = 0; n < 36; n++) begin
      rdy_prev = x_in_ready;
      @(posedge clk);
      check($sformatf("hs_accept%0d", n), {15'd0, rdy_prev}, {15'd0, (n % 6) == 0});
      if (rdy_prev) push(1'b1, 16'd0, 1'b1, 16'd0, $sformatf("hs%0d", n));
      @(negedge clk);
      check($sformatf("hs_ready%0d", n), {15'd0, x_in_ready}, {15'd0, (n % 6) == 5});
      check($sformatf("hs_valid%0d", n), {15'd0, y_out_valid}, {15'd0, (n % 6) >= 4});
    end
    drain();

    // Reset during MULT
    @(negedge clk);
    x_in = 16'd16384;
    x_in_valid = 1'b1;
    @(posedge clk);          // accepted: IDLE -> PAIR
    @(negedge clk);
    x_in_valid = 1'b0;
    @(posedge clk);          // PAIR -> MULT
    #1;
    reset_n = 1'b0;
    #1;
    check("inflight_ready", {15'd0, x_in_ready}, 16'd1);
    check("inflight_y_out", y_out, 16'd0);
    check("inflight_valid", {15'd0, y_out_valid}, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    vprev = n_valid;
    repeat (10) @(negedge clk);
    check("inflight_no_strobe", 16'(n_valid), 16'(vprev));
    send(16'd16384, 1'b1, 16'd1, 1'b1, 16'd0, "post_rst");
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
